// File: rtl/step_ctrl.sv
// rtl/step_ctrl.sv - button synchronizer/debouncer with single-step and free-run CPU clock-enable
// Each debounced button yields a rising-edge pulse; the step channel or a programmable divider drives CPU_EN.
module step_ctrl #(
  parameter int N_BTN     = 4,
  parameter int DB_CYCLES = 50000,
  parameter int STEP_CH   = 3,
  parameter int DIV_W     = 8,
  parameter int CNT_W     = 16
) (
  input  logic             CCLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] BTN,
  input  logic             MODE_RUN,
  input  logic             HALT,
  input  logic [DIV_W-1:0] RUN_DIV,
  output logic [N_BTN-1:0] BTN_DB,
  output logic [N_BTN-1:0] BTN_PULSE,
  output logic             CPU_EN,
  output logic [CNT_W-1:0] STEP_COUNT
);

  localparam int DB_W = 20;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [N_BTN-1:0] btn_s1;
  logic [N_BTN-1:0] btn_s2;
  logic             mode_s1;
  logic             mode_s2;
  logic [DB_W-1:0]  db_cnt [N_BTN];
  logic [N_BTN-1:0] db_next;
  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge CCLK or posedge RST) begin
    if (RST) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
    end else begin
      btn_s1  <= BTN;
      btn_s2  <= btn_s1;
      mode_s1 <= MODE_RUN;
      mode_s2 <= mode_s1;
    end
  end

  // A channel flips only when the mismatch has persisted for DB_CYCLES edges.
  always_comb begin
    db_next = BTN_DB;
    for (int i = 0; i < N_BTN; i++) begin
      if ((btn_s2[i] != BTN_DB[i]) && (db_cnt[i] == DB_LAST)) begin
        db_next[i] = btn_s2[i];
      end
    end
  end

  always_ff @(posedge CCLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt[i] <= '0;
      end
      BTN_DB    <= '0;
      BTN_PULSE <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if ((btn_s2[i] == BTN_DB[i]) || (db_cnt[i] == DB_LAST)) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
      BTN_DB    <= db_next;
      BTN_PULSE <= db_next & ~BTN_DB;
    end
  end

  // A divider left above a freshly lowered RUN_DIV never matches, so it wraps silently.
  always_ff @(posedge CCLK or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
    end else if (!mode_s2) begin
      div_cnt <= '0;
    end else if (!HALT) begin
      if (div_cnt >= RUN_DIV) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    CPU_EN = 1'b0;
    if (!HALT) begin
      if (mode_s2) begin
        CPU_EN = (div_cnt == RUN_DIV);
      end else begin
        CPU_EN = BTN_PULSE[STEP_CH];
      end
    end
  end

  always_ff @(posedge CCLK or posedge RST) begin
    if (RST) begin
      STEP_COUNT <= '0;
    end else if (CPU_EN) begin
      STEP_COUNT <= STEP_COUNT + 1'b1;
    end
  end

endmodule

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 Parameter N_BTN, default 4: number of raw button channels.
REQ-002 Parameter DB_CYCLES, default 50000: consecutive stable cycles for a debounced change; legal range 1..2^20-1; simulation uses 4.
REQ-003 Parameter STEP_CH, default 3: channel whose debounced press issues a single step; legal range 0..N_BTN-1.
REQ-004 Parameter DIV_W, default 8: width of the RUN_DIV input.
REQ-005 Parameter CNT_W, default 16: width of STEP_COUNT.
REQ-006 Port CCLK, input, 1: the single clock; all state updates on its rising edge.
REQ-007 Port RST, input, 1: reset, asynchronous, active-high.
REQ-008 Port BTN, input, N_BTN: raw asynchronous button levels.
REQ-009 Port MODE_RUN, input, 1: asynchronous level; 1 = free-run, 0 = single-step.
REQ-010 Port HALT, input, 1: synchronous level; 1 blocks all CPU_EN pulses.
REQ-011 Port RUN_DIV, input, DIV_W: free-run period minus one; sampled every cycle.
REQ-012 Port BTN_DB, output, N_BTN: debounced button levels.
REQ-013 Port BTN_PULSE, output, N_BTN: one-cycle pulse per debounced rising edge.
REQ-014 Port CPU_EN, output, 1: one-cycle clock-enable for the downstream CPU.
REQ-015 Port STEP_COUNT, output, CNT_W: number of CPU_EN pulses issued.

Function
REQ-016 Each BTN bit and MODE_RUN SHALL pass through a two-flop synchronizer; the synchronized value is s.
REQ-017 Each channel SHALL have a debounce counter: on an edge where s != BTN_DB, counter +1; on an edge where s == BTN_DB, counter cleared to 0.
REQ-018 When a mismatch edge finds the counter at DB_CYCLES-1, BTN_DB SHALL take s and the counter SHALL clear to 0 on that edge.
REQ-019 A raw change held stable SHALL reach BTN_DB exactly DB_CYCLES+2 rising edges after the first edge that samples it.
REQ-020 A glitch shorter than DB_CYCLES synchronized cycles SHALL leave BTN_DB unchanged.
REQ-021 BTN_PULSE[i] SHALL be registered and high for exactly the one cycle following the edge on which BTN_DB[i] goes 0->1.
REQ-022 Falling BTN_DB edges SHALL produce no pulse.
REQ-023 Step mode (synchronized MODE_RUN=0): CPU_EN SHALL be high for the cycle in which BTN_PULSE[STEP_CH] is high, unless HALT=1.
REQ-024 Run mode (synchronized MODE_RUN=1): a divider SHALL count 0..RUN_DIV; CPU_EN SHALL be high in the cycle the divider equals RUN_DIV, after which the divider returns to 0.
REQ-025 RUN_DIV=0 SHALL give CPU_EN high every cycle in run mode.
REQ-026 If RUN_DIV is lowered below the current divider value, the divider SHALL wrap to 0 on the next edge without pulsing.
REQ-027 In run mode, step-channel pulses SHALL be ignored; BTN_PULSE itself SHALL still be produced.
REQ-028 The divider SHALL clear to 0 in step mode, so the first run-mode CPU_EN occurs RUN_DIV+1 cycles after entering run mode.
REQ-029 HALT=1 SHALL force CPU_EN to 0 and freeze the divider; a step press while halted SHALL be discarded, not queued.
REQ-030 STEP_COUNT SHALL increment by 1 on every edge where CPU_EN=1, wrapping from 2^CNT_W-1 to 0.
REQ-031 A mode change coincident with a step pulse SHALL be governed by the synchronized mode value in that cycle.

Reset
REQ-032 RST=1 SHALL immediately clear all synchronizers, debounce counters, divider, BTN_DB, BTN_PULSE, CPU_EN and STEP_COUNT to 0, without waiting for a clock edge.
REQ-033 After RST deasserts, a button held through reset SHALL be debounced from scratch and SHALL produce exactly one BTN_PULSE.
REQ-034 RST asserted mid-debounce or mid-divide SHALL discard the partial count.

Verification (DB_CYCLES=4, STEP_CH=3, CNT_W=4)
REQ-035 Step mode, HALT=0, BTN[3] held 1 for 20 cycles -> BTN_DB[3] rises 6 edges after first sample; BTN_PULSE[3] and CPU_EN each high exactly 1 cycle; STEP_COUNT=1.
REQ-036 BTN[1] pulsed high for 3 cycles -> BTN_DB[1] and BTN_PULSE[1] remain 0.
REQ-037 Run mode, RUN_DIV=3, 40 cycles -> CPU_EN high every 4th cycle; STEP_COUNT=10; BTN[3] presses add no extra pulses.
REQ-038 Run mode with RUN_DIV=0 for 20 cycles -> STEP_COUNT wraps from 15 to 0 and reads 4.
REQ-039 HALT=1 during a step press, then HALT=0 -> no CPU_EN; STEP_COUNT unchanged.
REQ-040 RST pulsed asynchronously mid-cycle while run mode is counting -> all outputs read 0 before the next edge; after release, the first CPU_EN comes RUN_DIV+1 cycles after the synchronized mode goes high.
